rob_multi: RTL and testbench
============================

// Module: rob_multi
// PURPOSE
//  Parametrised multi-issue reorder buffer; next generation of the single-issue ROB.
//  Accepts up to DISP_W in-order dispatches and NUM_CDB writebacks per cycle.
//  Retires up to COMMIT_W completed head entries per cycle, in program order.
//  Detects branch mispredicts at commit and raises a one-cycle flush with a redirect PC.
// PARAMETERS
//  DEPTH      16  entries; power of two, >= 4
//  DISP_W      2  dispatch lanes per cycle
//  COMMIT_W    2  commit lanes per cycle
//  NUM_CDB     2  writeback ports
//  PAYLOAD_W  64  opaque per-entry payload (arch reg, phys reg, rvfi subset), returned at commit
//  TAG_W      $clog2(DEPTH)  entry index width
// PORTS
//  clk            in   1                    clock
//  rst            in   1                    reset
//  disp_valid     in   DISP_W               per-lane dispatch request; lane 0 is oldest
//  disp_payload   in   DISP_W*PAYLOAD_W     per-lane payload
//  disp_is_br     in   DISP_W               entry is conditional branch or jump
//  disp_pred      in   DISP_W               predicted taken
//  disp_pc        in   DISP_W*32            instruction PC
//  disp_ready     out  1                    free entries >= DISP_W
//  disp_tag       out  DISP_W*TAG_W         tag allocated to each lane this cycle
//  cdb_valid      in   NUM_CDB              writeback valid
//  cdb_tag        in   NUM_CDB*TAG_W        entry being completed
//  cdb_taken      in   NUM_CDB              resolved direction (branches only)
//  cdb_target     in   NUM_CDB*32           resolved taken target (branches only)
//  commit_en      in   1                    downstream may retire this cycle (0 = hold)
//  commit_valid   out  COMMIT_W             lane retires this cycle; lane 0 is oldest
//  commit_payload out  COMMIT_W*PAYLOAD_W   retiring payloads
//  commit_tag     out  COMMIT_W*TAG_W       retiring tags
//  flush          out  1                    mispredict flush (combinational)
//  flush_pc       out  32                   redirect PC
//  count          out  TAG_W+1              occupied entries
//  mispred_cnt    out  32                   saturating mispredict counter
// BEHAVIOUR
//  - head/tail are TAG_W+1 bits (wrap bit); count = tail - head; full when count == DEPTH.
//  - Reset (sync): head = tail = 0, all entries invalid/not done, mispred_cnt = 0.
//    Outputs after reset: disp_ready = 1, commit_valid = 0, flush = 0, count = 0.
//  - Dispatch: accepted only when disp_ready && !flush. Valid lanes must be a contiguous
//    prefix from lane 0; a non-prefix pattern is a protocol error and is not dispatched.
//    Lane i receives disp_tag[i] = tail + i (mod DEPTH); tail advances by popcount(disp_valid).
//  - Writeback: cdb_valid to an allocated, not-done entry sets done and latches taken/target;
//    writeback to an unallocated entry is ignored. Same-tag writes in one cycle: lowest port
//    wins. A writeback to the head entry is visible at commit the next cycle (1-cycle latency).
//  - Commit (combinational from state): lane k valid iff commit_en, entry head+k allocated and
//    done, lanes 0..k-1 valid, and no earlier lane mispredicted. Head advances by commit count.
//  - Mispredict: committing branch with taken != pred. That lane still commits; younger lanes
//    are suppressed; flush = 1 same cycle; flush_pc = taken ? target : pc + 4.
//  - Flush cycle: dispatch ignored, writebacks ignored; next edge all entries invalidated,
//    head = tail = 0, mispred_cnt += 1 (saturates at 2^32-1).
//  - Simultaneous dispatch + commit with ROB full: disp_ready uses current-cycle count only
//    (no same-cycle reuse of freed entries).
//  - Wrap-around: tags wrap modulo DEPTH; the wrap bit distinguishes full from empty.
//  - rst has priority over flush, dispatch and commit in the same cycle.
// TESTING
//  1. Reset, dispatch 2 lanes x 8 cycles (DEPTH=16) -> tags 0..15, disp_ready=0, count=16.
//  2. Writeback tags 1 then 0 -> cycle after tag 0 done: commit_valid=2'b11, tags 0,1.
//  3. Entry 0 done, entry 1 not done, entry 2 done -> commit_valid=2'b01 only; 2 waits on 1.
//  4. Branch pc=0x100, pred=0, cdb_taken=1, target=0x200 at head -> flush=1, flush_pc=0x200,
//     lane 1 suppressed; next cycle count=0, mispred_cnt=1.
//  5. Fill/drain 40 entries continuously -> head/tail wrap twice, commits in tag order, no loss.
//  6. Two CDB ports same tag, same cycle, different taken -> port 0 value retained;
//     rst asserted mid-stream -> count=0, commit_valid=0 next cycle.

Source files
------------

// File: rtl/rob_multi.sv
// Multi-issue reorder buffer: in-order dispatch, out-of-order writeback,
// in-order multi-lane commit with mispredict flush at retirement.
module rob_multi #(
  parameter int DEPTH     = 16,
  parameter int DISP_W    = 2,
  parameter int COMMIT_W  = 2,
  parameter int NUM_CDB   = 2,
  parameter int PAYLOAD_W = 64,
  parameter int TAG_W     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DISP_W-1:0]             disp_valid,
  input  logic [DISP_W*PAYLOAD_W-1:0]   disp_payload,
  input  logic [DISP_W-1:0]             disp_is_br,
  input  logic [DISP_W-1:0]             disp_pred,
  input  logic [DISP_W*32-1:0]          disp_pc,
  output logic                          disp_ready,
  output logic [DISP_W*TAG_W-1:0]       disp_tag,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
  input  logic [NUM_CDB-1:0]            cdb_taken,
  input  logic [NUM_CDB*32-1:0]         cdb_target,
  input  logic                          commit_en,
  output logic [COMMIT_W-1:0]           commit_valid,
  output logic [COMMIT_W*PAYLOAD_W-1:0] commit_payload,
  output logic [COMMIT_W*TAG_W-1:0]     commit_tag,
  output logic                          flush,
  output logic [31:0]                   flush_pc,
  output logic [TAG_W:0]                count,
  output logic [31:0]                   mispred_cnt
);

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [TAG_W:0]   ptr_t;

  ptr_t                 head, tail;
  logic [DEPTH-1:0]     alloc, done, is_br, pred, taken;
  logic [31:0]          pc_q  [DEPTH];
  logic [31:0]          tgt_q [DEPTH];
  logic [PAYLOAD_W-1:0] pl_q  [DEPTH];
  logic [31:0]          mis_q;

  ptr_t                 free_n, disp_n, cmt_n;
  logic                 prefix_ok, disp_fire, live;
  logic [COMMIT_W-1:0]  mis;
  logic [31:0]          fpc;
  tag_t                 cidx;

  assign count       = tail - head;
  assign free_n      = ptr_t'(DEPTH) - count;
  assign disp_ready  = free_n >= ptr_t'(DISP_W);
  assign mispred_cnt = mis_q;

  // x & (x+1) == 0 only for 0..01..1 patterns
  assign prefix_ok = (disp_valid & (disp_valid + DISP_W'(1))) == '0;
  assign disp_fire = disp_ready && !flush && prefix_ok && |disp_valid;

  always_comb begin
    disp_n   = '0;
    disp_tag = '0;
    for (int i = 0; i < DISP_W; i++) begin
      disp_n = disp_n + ptr_t'(disp_valid[i]);
      disp_tag[i*TAG_W +: TAG_W] = tail[TAG_W-1:0] + tag_t'(i);
    end
  end

  always_comb begin
    commit_valid   = '0;
    commit_payload = '0;
    commit_tag     = '0;
    mis            = '0;
    cmt_n          = '0;
    fpc            = '0;
    cidx           = '0;
    live           = commit_en;
    for (int k = 0; k < COMMIT_W; k++) begin
      cidx = head[TAG_W-1:0] + tag_t'(k);
      commit_tag[k*TAG_W +: TAG_W]         = cidx;
      commit_payload[k*PAYLOAD_W +: PAYLOAD_W] = pl_q[cidx];
      if (live && alloc[cidx] && done[cidx]) begin
        commit_valid[k] = 1'b1;
        cmt_n = cmt_n + ptr_t'(1);
        if (is_br[cidx] && (taken[cidx] != pred[cidx])) begin
          mis[k] = 1'b1;
          fpc    = taken[cidx] ? tgt_q[cidx] : pc_q[cidx] + 32'd4;
          live   = 1'b0;
        end
      end else begin
        live = 1'b0;
      end
    end
  end

  assign flush    = |mis;
  assign flush_pc = fpc;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      alloc <= '0;
      done  <= '0;
      mis_q <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      alloc <= '0;
      done  <= '0;
      if (mis_q != '1)
        mis_q <= mis_q + 32'd1;
    end else begin
      for (int k = 0; k < COMMIT_W; k++)
        if (commit_valid[k])
          alloc[commit_tag[k*TAG_W +: TAG_W]] <= 1'b0;
      head <= head + cmt_n;
      // descending so that port 0 is written last and wins
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
        if (cdb_valid[p] && alloc[cdb_tag[p*TAG_W +: TAG_W]] &&
            !done[cdb_tag[p*TAG_W +: TAG_W]]) begin
          done[cdb_tag[p*TAG_W +: TAG_W]]  <= 1'b1;
          taken[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_taken[p];
          tgt_q[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_target[p*32 +: 32];
        end
      end
      if (disp_fire) begin
        for (int i = 0; i < DISP_W; i++) begin
          if (disp_valid[i]) begin
            alloc[disp_tag[i*TAG_W +: TAG_W]] <= 1'b1;
            done[disp_tag[i*TAG_W +: TAG_W]]  <= 1'b0;
            is_br[disp_tag[i*TAG_W +: TAG_W]] <= disp_is_br[i];
            pred[disp_tag[i*TAG_W +: TAG_W]]  <= disp_pred[i];
            pc_q[disp_tag[i*TAG_W +: TAG_W]]  <= disp_pc[i*32 +: 32];
            pl_q[disp_tag[i*TAG_W +: TAG_W]]  <=
              disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
          end
        end
        tail <= tail + disp_n;
      end
    end
  end

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: fill, commit ordering, mispredict flush,
// CDB port priority, reset mid-stream and pointer wrap-around.
module tb_rob_multi;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   disp_valid, disp_is_br, disp_pred;
  logic [127:0] disp_payload;
  logic [63:0]  disp_pc;
  logic         disp_ready;
  logic [7:0]   disp_tag;
  logic [1:0]   cdb_valid, cdb_taken;
  logic [7:0]   cdb_tag;
  logic [63:0]  cdb_target;
  logic         commit_en;
  logic [1:0]   commit_valid;
  logic [127:0] commit_payload;
  logic [7:0]   commit_tag;
  logic         flush;
  logic [31:0]  flush_pc;
  logic [4:0]   count;
  logic [31:0]  mispred_cnt;

  int total = 0;
  int bad   = 0;

  rob_multi dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_payload(disp_payload),
    .disp_is_br(disp_is_br), .disp_pred(disp_pred), .disp_pc(disp_pc),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_taken(cdb_taken),
    .cdb_target(cdb_target), .commit_en(commit_en),
    .commit_valid(commit_valid), .commit_payload(commit_payload),
    .commit_tag(commit_tag), .flush(flush), .flush_pc(flush_pc),
    .count(count), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task idle;
    disp_valid   = '0;
    disp_is_br   = '0;
    disp_pred    = '0;
    disp_payload = '0;
    disp_pc      = '0;
    cdb_valid    = '0;
    cdb_tag      = '0;
    cdb_taken    = '0;
    cdb_target   = '0;
    commit_en    = 1'b0;
  endtask

  task test_reset;
    @(negedge clk); idle(); rst = 1'b1;
    @(posedge clk);
    @(negedge clk); rst = 1'b0; commit_en = 1'b1; #1;
    total++;
    if (disp_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", disp_ready);
    end
    total++;
    if (commit_valid !== 2'b00 || flush !== 1'b0) begin
      bad++; $display("FAIL reset_commit got=%b/%b exp=00/0", commit_valid, flush);
    end
    total++;
    if (count !== 5'd0 || mispred_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_count got=%0d/%0d exp=0/0", count, mispred_cnt);
    end
    @(posedge clk);
  endtask

  task test_fill;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); idle();
      disp_valid = 2'b11;
      for (int l = 0; l < 2; l++) begin
        disp_payload[l*64 +: 64] = 64'h1000 + 64'(2*c + l);
        disp_pc[l*32 +: 32]      = 32'h1000 + 32'(4*(2*c + l));
      end
      #1;
      total++;
      if (disp_tag !== {4'(2*c+1), 4'(2*c)} || disp_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_tag c=%0d got=%h/%b exp=%h/1", c, disp_tag,
                 disp_ready, {4'(2*c+1), 4'(2*c)});
      end
      @(posedge clk);
    end
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd16 || disp_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full got=%0d/%b exp=16/0", count, disp_ready);
    end
    disp_valid = 2'b11;
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd16) begin
      bad++; $display("FAIL fill_overflow got=%0d exp=16", count);
    end
  endtask

  task test_commit_pair;
    @(negedge clk); idle(); commit_en = 1'b1;
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd1; #1;
    total++;
    if (commit_valid !== 2'b00) begin
      bad++; $display("FAIL pair_early got=%b exp=00", commit_valid);
    end
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1;
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd0; #1;
    total++;
    if (commit_valid !== 2'b00) begin
      bad++; $display("FAIL pair_latency got=%b exp=00", commit_valid);
    end
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; disp_valid = 2'b11; #1;
    total++;
    if (commit_valid !== 2'b11 || commit_tag !== {4'd1, 4'd0}) begin
      bad++; $display("FAIL pair_commit got=%b/%h exp=11/10", commit_valid, commit_tag);
    end
    total++;
    if (commit_payload !== {64'h1001, 64'h1000} || disp_ready !== 1'b0) begin
      bad++; $display("FAIL pair_payload got=%h/%b exp=1001_1000/0",
                      commit_payload, disp_ready);
    end
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd14) begin
      bad++; $display("FAIL pair_count got=%0d exp=14", count);
    end
  endtask

  task test_partial;
    @(negedge clk); idle(); commit_en = 1'b1;
    cdb_valid = 2'b11; cdb_tag = {4'd4, 4'd2};
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; #1;
    total++;
    if (commit_valid !== 2'b01 || commit_tag[3:0] !== 4'd2 ||
        commit_payload[63:0] !== 64'h1002) begin
      bad++; $display("FAIL partial_one got=%b/%h/%h exp=01/2/1002",
                      commit_valid, commit_tag[3:0], commit_payload[63:0]);
    end
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1;
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd3; #1;
    total++;
    if (commit_valid !== 2'b00 || count !== 5'd13) begin
      bad++; $display("FAIL partial_wait got=%b/%0d exp=00/13", commit_valid, count);
    end
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (commit_valid !== 2'b00) begin
      bad++; $display("FAIL partial_hold got=%b exp=00", commit_valid);
    end
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; #1;
    total++;
    if (commit_valid !== 2'b11 || commit_tag !== {4'd4, 4'd3}) begin
      bad++; $display("FAIL partial_pair got=%b/%h exp=11/43", commit_valid, commit_tag);
    end
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd11) begin
      bad++; $display("FAIL partial_count got=%0d exp=11", count);
    end
  endtask

  task test_rst_mid;
    @(negedge clk); idle(); rst = 1'b1; commit_en = 1'b1;
    cdb_valid = 2'b01; cdb_tag[3:0] = 4'd5; disp_valid = 2'b11;
    @(posedge clk);
    @(negedge clk); idle(); rst = 1'b0; commit_en = 1'b1; #1;
    total++;
    if (count !== 5'd0 || commit_valid !== 2'b00 || disp_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid got=%0d/%b/%b exp=0/00/1",
                      count, commit_valid, disp_ready);
    end
    @(posedge clk);
  endtask

  task test_mispredict;
    @(negedge clk); idle(); disp_valid = 2'b11; disp_is_br = 2'b01;
    disp_pc = {32'h104, 32'h100}; disp_payload = {64'hB1, 64'hB0}; #1;
    total++;
    if (disp_tag !== {4'd1, 4'd0}) begin
      bad++; $display("FAIL mis_tag got=%h exp=10", disp_tag);
    end
    @(posedge clk);
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag = {4'd1, 4'd0};
    cdb_taken = 2'b01; cdb_target = {32'h0, 32'h200};
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; disp_valid = 2'b11; #1;
    total++;
    if (flush !== 1'b1 || flush_pc !== 32'h200) begin
      bad++; $display("FAIL mis_flush got=%b/%h exp=1/200", flush, flush_pc);
    end
    total++;
    if (commit_valid !== 2'b01 || commit_payload[63:0] !== 64'hB0) begin
      bad++; $display("FAIL mis_suppress got=%b/%h exp=01/b0",
                      commit_valid, commit_payload[63:0]);
    end
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd0 || mispred_cnt !== 32'd1 || flush !== 1'b0) begin
      bad++; $display("FAIL mis_after got=%0d/%0d/%b exp=0/1/0",
                      count, mispred_cnt, flush);
    end
    disp_valid = 2'b11; disp_is_br = 2'b11; disp_pred = 2'b11;
    disp_pc = {32'h300, 32'h2F0};
    @(posedge clk);
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag = {4'd1, 4'd0};
    cdb_taken = 2'b01; cdb_target = {32'h999, 32'h888};
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; #1;
    total++;
    if (commit_valid !== 2'b11 || flush !== 1'b1 || flush_pc !== 32'h304) begin
      bad++; $display("FAIL mis_nt got=%b/%b/%h exp=11/1/304",
                      commit_valid, flush, flush_pc);
    end
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd0 || mispred_cnt !== 32'd2) begin
      bad++; $display("FAIL mis_nt_after got=%0d/%0d exp=0/2", count, mispred_cnt);
    end
  endtask

  task test_same_tag;
    @(negedge clk); idle(); disp_valid = 2'b01; disp_is_br = 2'b01;
    disp_pc[31:0] = 32'h400;
    @(posedge clk);
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag = {4'd0, 4'd0};
    cdb_taken = 2'b10; cdb_target = {32'h222, 32'h111};
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; #1;
    total++;
    if (flush !== 1'b0 || commit_valid !== 2'b01) begin
      bad++; $display("FAIL same_tag_p0 got=%b/%b exp=0/01", flush, commit_valid);
    end
    @(posedge clk);
    @(negedge clk); idle(); disp_valid = 2'b01; disp_is_br = 2'b01;
    disp_pc[31:0] = 32'h500; #1;
    total++;
    if (disp_tag[3:0] !== 4'd1) begin
      bad++; $display("FAIL same_tag_alloc got=%h exp=1", disp_tag[3:0]);
    end
    @(posedge clk);
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag = {4'd1, 4'd1};
    cdb_taken = 2'b01; cdb_target = {32'h777, 32'h600};
    @(posedge clk);
    @(negedge clk); idle(); commit_en = 1'b1; #1;
    total++;
    if (flush !== 1'b1 || flush_pc !== 32'h600) begin
      bad++; $display("FAIL same_tag_p0_taken got=%b/%h exp=1/600", flush, flush_pc);
    end
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd0 || mispred_cnt !== 32'd3) begin
      bad++; $display("FAIL same_tag_after got=%0d/%0d exp=0/3", count, mispred_cnt);
    end
  endtask

  task test_protocol;
    @(negedge clk); idle(); disp_valid = 2'b10;
    @(posedge clk);
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd0) begin
      bad++; $display("FAIL protocol_gap got=%0d exp=0", count);
    end
  endtask

  task test_back_to_back;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk); idle(); commit_en = 1'b1;
      if (c < 20) begin
        disp_valid = 2'b11;
        for (int l = 0; l < 2; l++)
          disp_payload[l*64 +: 64] = 64'h5000 + 64'(2*c + l);
      end
      if (c >= 1 && c <= 20) begin
        cdb_valid = 2'b11;
        cdb_tag   = {4'(2*(c-1)), 4'(2*(c-1)+1)};
      end
      #1;
      if (c < 20) begin
        total++;
        if (disp_tag !== {4'(2*c+1), 4'(2*c)} || disp_ready !== 1'b1) begin
          bad++; $display("FAIL wrap_disp c=%0d got=%h/%b exp=%h/1", c,
                          disp_tag, disp_ready, {4'(2*c+1), 4'(2*c)});
        end
      end
      total++;
      if (c >= 2) begin
        if (commit_valid !== 2'b11 ||
            commit_tag !== {4'(2*(c-2)+1), 4'(2*(c-2))} ||
            commit_payload !== {64'h5000 + 64'(2*(c-2)+1),
                                64'h5000 + 64'(2*(c-2))}) begin
          bad++; $display("FAIL wrap_commit c=%0d got=%b/%h/%h", c,
                          commit_valid, commit_tag, commit_payload);
        end
      end else if (commit_valid !== 2'b00) begin
        bad++; $display("FAIL wrap_early c=%0d got=%b exp=00", c, commit_valid);
      end
      @(posedge clk);
    end
    @(negedge clk); idle(); #1;
    total++;
    if (count !== 5'd0 || disp_tag[3:0] !== 4'd8) begin
      bad++; $display("FAIL wrap_drain got=%0d/%h exp=0/8", count, disp_tag[3:0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_commit_pair();
    test_partial();
    test_rst_mid();
    test_mispredict();
    test_same_tag();
    test_protocol();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
